// File: rtl/mem_scan_ctrl_if.sv
// rtl/mem_scan_ctrl_if.sv - control/status bundle between a scan requester and mem_scan_ctrl
interface mem_scan_ctrl_if #(
  parameter int ADDR_W = 16
);
  logic              step_mem;
  logic              run;
  logic              dir;
  logic              wrap;
  logic              load;
  logic [ADDR_W-1:0] load_addr;
  logic [ADDR_W-1:0] q;
  logic              step_out;
  logic              running;
  logic              done;

  modport master (
    output step_mem, run, dir, wrap, load, load_addr,
    input  q, step_out, running, done
  );

  modport slave (
    input  step_mem, run, dir, wrap, load, load_addr,
    output q, step_out, running, done
  );
endinterface

// File: rtl/mem_scan_ctrl.sv
// rtl/mem_scan_ctrl.sv - memory scan address generator with manual step, auto-run divider and wrap/stop ends
module mem_scan_ctrl #(
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 256,
  parameter int PERIOD = 4
) (
  input  logic          clk,
  input  logic          reset,
  mem_scan_ctrl_if.slave bus
);

  localparam int                DIV_W    = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(PERIOD - 1);
  localparam logic [ADDR_W-1:0] LAST     = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_nx;
  logic [DIV_W-1:0]  div, div_nx;
  logic [ADDR_W-1:0] q_r, q_nx;
  logic              step_d;
  logic              step_edge;
  logic              do_step;
  logic              at_end;
  logic              step_out_r, step_out_nx;
  logic              running_r, done_r;

  assign step_edge = bus.step_mem & ~step_d;
  assign at_end    = bus.dir ? (q_r == '0) : (q_r == LAST);

  always_comb begin
    state_nx    = state;
    div_nx      = div;
    q_nx        = q_r;
    step_out_nx = 1'b0;
    do_step     = 1'b0;
    if (bus.load) begin
      // load wins over any step this cycle and always lands in IDLE
      q_nx     = (bus.load_addr > LAST) ? LAST : bus.load_addr;
      state_nx = IDLE;
      div_nx   = '0;
    end else begin
      case (state)
        IDLE: begin
          do_step = step_edge;
          if (bus.run) begin
            state_nx = RUN;
            div_nx   = '0;
          end
        end
        RUN: begin
          if (!bus.run) begin
            state_nx = IDLE;
            div_nx   = '0;
          end else if (div == DIV_LAST) begin
            div_nx  = '0;
            do_step = 1'b1;
          end else begin
            div_nx = div + DIV_W'(1);
          end
        end
        DONE: begin
          if (!bus.run) state_nx = IDLE;
        end
        default: state_nx = IDLE;
      endcase

      if (do_step) begin
        if (!at_end) begin
          q_nx        = bus.dir ? (q_r - ADDR_W'(1)) : (q_r + ADDR_W'(1));
          step_out_nx = 1'b1;
        end else if (bus.wrap) begin
          q_nx        = bus.dir ? LAST : '0;
          step_out_nx = 1'b1;
        end else begin
          state_nx = DONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      div        <= '0;
      q_r        <= '0;
      step_d     <= 1'b0;
      step_out_r <= 1'b0;
      running_r  <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state      <= state_nx;
      div        <= div_nx;
      q_r        <= q_nx;
      step_d     <= bus.step_mem;
      step_out_r <= step_out_nx;
      running_r  <= (state_nx == RUN);
      done_r     <= (state_nx == DONE);
    end
  end

  assign bus.q        = q_r;
  assign bus.step_out = step_out_r;
  assign bus.running  = running_r;
  assign bus.done     = done_r;

endmodule

// File: doc/mem_scan_ctrl.md
MEM_SCAN_CTRL -- requirements
Module: mem_scan_ctrl

Parameters
REQ-001 SHALL provide parameters, one per line:
  ADDR_W, 16, width of scan address output q.
  DEPTH, 256, number of addressable locations; legal range 2..2**ADDR_W.
  PERIOD, 4, clock cycles between auto-run steps; legal range 1..65535.

Interface
REQ-002 SHALL provide these ports, one per line:
  clk        input   1       single clock; all logic on rising edge.
  reset      input   1       synchronous, active-high reset.
  step_mem   input   1       manual step request; rising-edge detected.
  run        input   1       level; 1 requests auto-run scanning.
  dir        input   1       0 = count up, 1 = count down.
  wrap       input   1       1 = wrap at end address, 0 = stop at end address.
  load       input   1       1-cycle strobe; loads load_addr into q.
  load_addr  input   ADDR_W  load value.
  q          output  ADDR_W  current scan address, registered.
  step_out   output  1       registered 1-cycle pulse in the cycle q changes by a step (not by load or reset).
  running    output  1       1 while in state RUN.
  done       output  1       1 while in state DONE.

Function
REQ-003 SHALL register step_mem into step_d each cycle; a step edge is step_mem=1 and step_d=0.
REQ-004 SHALL implement states IDLE, RUN and DONE.
REQ-005 SHALL define end address as DEPTH-1 when dir=0 and 0 when dir=1; dir and wrap are sampled on every step.
REQ-006 A step SHALL set q to q+1 (dir=0) or q-1 (dir=1) when q is not at the end address.
REQ-007 A step at the end address with wrap=1 SHALL set q to 0 (dir=0) or DEPTH-1 (dir=1), and the state SHALL remain unchanged.
REQ-008 A step at the end address with wrap=0 SHALL hold q, SHALL NOT pulse step_out, and SHALL move the state to DONE.
REQ-009 In IDLE, a step edge SHALL perform exactly one step; run=1 SHALL move the state to RUN and clear the divider to 0.
REQ-010 In RUN, the divider SHALL count 0..PERIOD-1 and perform one step in each cycle it equals PERIOD-1, then return to 0.
  - First auto step: PERIOD cycles after entering RUN.
  - Step edges: ignored.
  - run=0: go to IDLE; q holds; divider clears.
REQ-011 In DONE, q SHALL hold and step edges SHALL be ignored; run=0 SHALL move the state to IDLE.
REQ-012 A load in any state SHALL set q to min(load_addr, DEPTH-1), move the state to IDLE, clear the divider, and suppress any step in the same cycle.
  - Priority: reset > load > step.
  - If run=1, RUN is re-entered in the following cycle per REQ-009.
REQ-013 step_out SHALL assert in the same clock edge that q updates on a step, for exactly one cycle per step.
REQ-014 All outputs SHALL be registered; no combinational input-to-output paths.
REQ-015 Arithmetic SHALL be modulo-free: q never leaves 0..DEPTH-1 under any input sequence.

Reset
REQ-016 reset=1 at a rising clk edge SHALL force the following values, overriding all other inputs including load:
  - q=0, step_d=0, divider=0.
  - state=IDLE.
  - step_out=0, running=0, done=0.
REQ-017 Reset asserted mid-RUN or in DONE SHALL take effect at the next edge, with no further step.

Verification (DEPTH=16, ADDR_W=8, PERIOD=4 unless stated)
REQ-018 Manual step, covering:
  - After reset, hold step_mem=1 for 5 cycles: q=1 exactly once, with one step_out pulse.
  - Release step_mem and re-press it: q=2.
REQ-019 Wrap up: load 14, dir=0, wrap=1, run=1: q changes 14->15->0->1 at 4-cycle spacing, and the first change occurs 4 cycles after running rises.
REQ-020 Stop down: load 2, dir=1, wrap=0, run=1: q goes 2->1->0, then done=1 and running=0; q stays 0 with no step_out; drop run: done=0 and the state is IDLE.
REQ-021 Load clamp and priority:
  - load_addr=200 with load=1 and a simultaneous step edge: q=15, step_out=0.
  - Same cycle with reset=1: q=0.
REQ-022 Mid-run reset: assert reset in RUN when divider=2: the next edge gives q=0 and running=0, with no step_out; with run still 1 after reset is released, RUN is entered and the first step comes PERIOD cycles later.
REQ-023 PERIOD=1 with wrap=1: q increments every cycle during RUN, and step_out stays high continuously.
